// File: rtl/ecg_fetch_pkg.sv
// Shared definitions for the ECG sample fetcher: FSM state encoding,
// default parameter values and the channel-index width helper.
package ecg_fetch_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DIV    = 2;
  localparam int unsigned DEF_NUM_CH = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_DONE
  } fetch_state_e;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ecg_clk_div.sv
// Sample-clock divider: 50% duty strobe of period 2*DIV while enabled,
// plus a combinational strobe flagging the cycle whose edge drives it low.
module ecg_clk_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic load_i,
  output logic sample_clk_o,
  output logic fall_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       terminal;

  assign terminal     = (cnt_q == 8'(DIV - 1));
  assign fall_o       = en_i && sclk_q && terminal;
  assign sample_clk_o = sclk_q;

  always_comb begin
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (load_i) begin
      // Entering RUN: start high with a fresh count.
      sclk_d = 1'b1;
    end else if (en_i) begin
      if (terminal) begin
        sclk_d = ~sclk_q;
      end else begin
        cnt_d  = cnt_q + 8'd1;
        sclk_d = sclk_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/ecg_sample_fetcher.sv
// Walks a sample-memory address range (optionally looping) and paces it
// with a divided sample clock; channel index tracks interleaved frames.
module ecg_sample_fetcher
  import ecg_fetch_pkg::*;
#(
  parameter  int unsigned ADDR_W = DEF_ADDR_W,
  parameter  int unsigned DIV    = DEF_DIV,
  parameter  int unsigned NUM_CH = DEF_NUM_CH,
  localparam int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] address,
  output logic [CH_W-1:0]   ch_idx,
  output logic              addr_valid,
  output logic              sample_clk,
  output logic              busy,
  output logic              done,
  output logic              wrapped
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_en, div_load, fall;

  assign div_en   = (state_q == ST_RUN)   && !stop;
  assign div_load = (state_q == ST_PRIME) && !stop;

  ecg_clk_div #(
    .DIV (DIV)
  ) u_div (
    .clk          (clk),
    .reset        (reset),
    .en_i         (div_en),
    .load_i       (div_load),
    .sample_clk_o (sample_clk),
    .fall_o       (fall)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    last_d  = last_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_PRIME;
            addr_d  = base_addr;
            base_d  = base_addr;
            last_d  = last_addr;
            ch_d    = '0;
            valid_d = 1'b1;
          end
        end
        ST_PRIME: state_d = ST_RUN;
        ST_RUN: begin
          if (fall) begin
            if (addr_q == last_q) begin
              if (loop_en) begin
                addr_d  = base_q;
                ch_d    = '0;
                wrap_d  = 1'b1;
                valid_d = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              addr_d  = addr_q + 1'b1;
              ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_PRIME) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      last_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign address    = addr_q;
  assign ch_idx     = ch_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wrapped    = wrap_q;

endmodule
